// File: rtl/led_ctrl_pkg.sv
// Shared encodings for the LED pattern sequencer.
// LED_PATTERN_CTRL_BOUNCE_EN selects BOUNCE instead of BLINK for mode 3.
package led_ctrl_pkg;

  localparam int unsigned PERIOD_W = 4;

  typedef enum logic [1:0] {
    MODE_OFF = 2'd0,
    MODE_SHL = 2'd1,
    MODE_SHR = 2'd2,
    MODE_ALT = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    S_OFF  = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_HOLD = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    SEED_ZERO = 2'd0,
    SEED_LSB  = 2'd1,
    SEED_MSB  = 2'd2,
    SEED_ONES = 2'd3
  } seed_e;

  function automatic seed_e seed_sel(input mode_e mode);
    seed_e sel;
    sel = SEED_ZERO;
    unique case (mode)
      MODE_OFF: sel = SEED_ZERO;
      MODE_SHL: sel = SEED_LSB;
      MODE_SHR: sel = SEED_MSB;
`ifdef LED_PATTERN_CTRL_BOUNCE_EN
      MODE_ALT: sel = SEED_LSB;
`else
      MODE_ALT: sel = SEED_ONES;
`endif
      default:  sel = SEED_ZERO;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/led_tick_gen.sv
// Prescaler plus step counter; emits a one-cycle step pulse every
// (CLK_DIV+1)*(period+1) enabled cycles.
module led_tick_gen
  import led_ctrl_pkg::*;
#(
  parameter int unsigned CLK_DIV = 2_499_999,
  parameter int unsigned CNT_W   = 24
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clr,
  input  logic                en,
  input  logic [PERIOD_W-1:0] period,
  output logic                step
);

  logic [CNT_W-1:0]    presc_q, presc_d;
  logic [PERIOD_W-1:0] stepc_q, stepc_d;
  logic                presc_wrap;

  assign presc_wrap = (presc_q == CNT_W'(CLK_DIV));
  assign step       = en && presc_wrap && (stepc_q == period);

  always_comb begin
    presc_d = presc_q;
    stepc_d = stepc_q;
    if (clr) begin
      presc_d = '0;
      stepc_d = '0;
    end else if (en) begin
      presc_d = presc_wrap ? '0 : presc_q + CNT_W'(1);
      if (presc_wrap) begin
        stepc_d = (stepc_q == period) ? '0 : stepc_q + PERIOD_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      presc_q <= '0;
      stepc_q <= '0;
    end else begin
      presc_q <= presc_d;
      stepc_q <= stepc_d;
    end
  end

endmodule

// File: rtl/led_pattern_ctrl.sv
// Commandable LED pattern engine: valid/ready mode commands, pausable stepping.
// LED_PATTERN_CTRL_BOUNCE_EN turns mode 3 into BOUNCE (adds a direction register).
module led_pattern_ctrl
  import led_ctrl_pkg::*;
#(
  parameter int unsigned CLK_DIV = 2_499_999,
  parameter int unsigned CNT_W   = 24,
  parameter int unsigned LED_NUM = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [1:0]          cmd_mode,
  input  logic [PERIOD_W-1:0] cmd_period,
  input  logic                pause,
  output logic [LED_NUM-1:0]  led_sig,
  output logic [1:0]          mode_cur
);

  state_e              state_q, state_d;
  mode_e               mode_lat_q, mode_lat_d;
  mode_e               mode_cur_q, mode_cur_d;
  logic [PERIOD_W-1:0] period_q, period_d;
  logic [LED_NUM-1:0]  led_q, led_d;
  logic [LED_NUM-1:0]  led_seed, led_step, rot_l, rot_r;
  logic                accept, tick_clr, tick_en, step;
`ifdef LED_PATTERN_CTRL_BOUNCE_EN
  logic                dir_q, dir_d, dir_step;  // 1 = moving towards the MSB
`endif

  assign cmd_ready = (state_q != S_LOAD);
  assign accept    = cmd_valid && cmd_ready;
  assign led_sig   = led_q;
  assign mode_cur  = mode_cur_q;

  led_tick_gen #(
    .CLK_DIV(CLK_DIV),
    .CNT_W  (CNT_W)
  ) u_tick_gen (
    .clk   (clk),
    .rst   (rst),
    .clr   (tick_clr),
    .en    (tick_en),
    .period(period_q),
    .step  (step)
  );

  always_comb begin
    led_seed = '0;
    unique case (seed_sel(mode_lat_q))
      SEED_ZERO: led_seed = '0;
      SEED_LSB:  led_seed = LED_NUM'(1);
      SEED_MSB:  led_seed = {1'b1, {(LED_NUM-1){1'b0}}};
      SEED_ONES: led_seed = '1;
      default:   led_seed = '0;
    endcase
  end

  assign rot_l = {led_q[LED_NUM-2:0], led_q[LED_NUM-1]};
  assign rot_r = {led_q[0], led_q[LED_NUM-1:1]};

  always_comb begin
    led_step = led_q;
`ifdef LED_PATTERN_CTRL_BOUNCE_EN
    dir_step = dir_q;
`endif
    unique case (mode_cur_q)
      MODE_SHL: led_step = rot_l;
      MODE_SHR: led_step = rot_r;
`ifdef LED_PATTERN_CTRL_BOUNCE_EN
      MODE_ALT: begin
        led_step = dir_q ? rot_l : rot_r;
        // Reverse once the lit bit reaches either end.
        if (led_step[LED_NUM-1]) begin
          dir_step = 1'b0;
        end else if (led_step[0]) begin
          dir_step = 1'b1;
        end
      end
`else
      MODE_ALT: led_step = ~led_q;
`endif
      default:  led_step = led_q;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    mode_lat_d = mode_lat_q;
    mode_cur_d = mode_cur_q;
    period_d   = period_q;
    led_d      = led_q;
    tick_clr   = 1'b0;
    tick_en    = 1'b0;
`ifdef LED_PATTERN_CTRL_BOUNCE_EN
    dir_d      = dir_q;
`endif
    // A command outranks both a pending step and pause.
    if (accept) begin
      state_d    = S_LOAD;
      mode_lat_d = mode_e'(cmd_mode);
      period_d   = cmd_period;
    end else begin
      unique case (state_q)
        S_LOAD: begin
          tick_clr   = 1'b1;
          mode_cur_d = mode_lat_q;
          led_d      = led_seed;
`ifdef LED_PATTERN_CTRL_BOUNCE_EN
          dir_d      = 1'b1;
`endif
          state_d    = (mode_lat_q == MODE_OFF) ? S_OFF : S_RUN;
        end
        S_RUN: begin
          if (pause) begin
            state_d = S_HOLD;
          end else begin
            tick_en = 1'b1;
            if (step) begin
              led_d = led_step;
`ifdef LED_PATTERN_CTRL_BOUNCE_EN
              dir_d = dir_step;
`endif
            end
          end
        end
        S_HOLD: begin
          if (!pause) begin
            state_d = S_RUN;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_OFF;
      mode_lat_q <= MODE_OFF;
      mode_cur_q <= MODE_OFF;
      period_q   <= '0;
      led_q      <= '0;
`ifdef LED_PATTERN_CTRL_BOUNCE_EN
      dir_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      mode_lat_q <= mode_lat_d;
      mode_cur_q <= mode_cur_d;
      period_q   <= period_d;
      led_q      <= led_d;
`ifdef LED_PATTERN_CTRL_BOUNCE_EN
      dir_q      <= dir_d;
`endif
    end
  end

endmodule

// File: tb/tb_led_pattern_ctrl.sv
// Self-checking bench for led_pattern_ctrl: directed scenarios plus random
// commands/pause, checked every cycle against an elapsed-cycle reference model.
module tb_led_pattern_ctrl;

  localparam int unsigned CLK_DIV = 3;
  localparam int unsigned CNT_W   = 4;
  localparam int unsigned LED_NUM = 4;
  localparam int          MASK    = (1 << LED_NUM) - 1;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       cmd_valid = 1'b0;
  logic [1:0] cmd_mode = 2'd0;
  logic [3:0] cmd_period = 4'd0;
  logic       pause = 1'b0;
  logic       cmd_ready;
  logic [LED_NUM-1:0] led_sig;
  logic [1:0] mode_cur;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state
  int m_led, m_mode, m_pend, m_pmode, m_pperiod, m_period;
  int m_elapsed, m_running, m_paused, m_pos, m_left;

  always #5 clk = ~clk;

  led_pattern_ctrl #(
    .CLK_DIV(CLK_DIV),
    .CNT_W  (CNT_W),
    .LED_NUM(LED_NUM)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_mode  (cmd_mode),
    .cmd_period(cmd_period),
    .pause     (pause),
    .led_sig   (led_sig),
    .mode_cur  (mode_cur)
  );

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_cmp++;
    assert (observed === expected) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  function automatic int interval();
    return (CLK_DIV + 1) * (m_period + 1);
  endfunction

  task automatic model_reset();
    m_led = 0; m_mode = 0; m_pend = 0; m_pmode = 0; m_pperiod = 0; m_period = 0;
    m_elapsed = 0; m_running = 0; m_paused = 0; m_pos = 0; m_left = 1;
  endtask

  task automatic model_seed(input int mode);
    m_pos = 0;
    m_left = 1;
    case (mode)
      1: m_led = 1;
      2: m_led = 1 << (LED_NUM - 1);
`ifdef LED_PATTERN_CTRL_BOUNCE_EN
      3: m_led = 1;
`else
      3: m_led = MASK;
`endif
      default: m_led = 0;
    endcase
  endtask

  task automatic model_step();
    case (m_mode)
      1: m_led = ((m_led << 1) | (m_led >> (LED_NUM - 1))) & MASK;
      2: m_led = ((m_led >> 1) | (m_led << (LED_NUM - 1))) & MASK;
`ifdef LED_PATTERN_CTRL_BOUNCE_EN
      3: begin
        m_pos = m_left ? m_pos + 1 : m_pos - 1;
        if (m_pos == LED_NUM - 1) m_left = 0;
        else if (m_pos == 0) m_left = 1;
        m_led = 1 << m_pos;
      end
`else
      3: m_led = (~m_led) & MASK;
`endif
      default: ;
    endcase
  endtask

  // Advance the model by one rising edge using the inputs present at that edge.
  task automatic model_edge();
    if (!rst) begin
      model_reset();
      return;
    end
    if (m_pend) begin
      m_pend = 0;
      m_mode = m_pmode;
      m_period = m_pperiod;
      model_seed(m_pmode);
      m_elapsed = 0;
      m_running = (m_pmode != 0);
      m_paused = 0;
    end else if (cmd_valid) begin
      m_pend = 1;
      m_pmode = int'(cmd_mode);
      m_pperiod = int'(cmd_period);
    end else if (m_running && !m_paused) begin
      if (pause) m_paused = 1;
      else begin
        m_elapsed++;
        if (m_elapsed % interval() == 0) model_step();
      end
    end else if (m_paused && !pause) begin
      m_paused = 0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check("led_sig", 32'(led_sig), 32'(m_led));
    check("mode_cur", 32'(mode_cur), 32'(m_mode));
    check("cmd_ready", 32'(cmd_ready), 32'(m_pend == 0));
  endtask

  task automatic issue(input int mode, input int period);
    cmd_valid = 1'b1;
    cmd_mode = 2'(mode);
    cmd_period = 4'(period);
    tick();
    check("ready_low_after_accept", 32'(cmd_ready), 32'd0);
    cmd_valid = 1'b0;
    tick();
    check("ready_back_high", 32'(cmd_ready), 32'd1);
  endtask

  initial begin
    int exp_shl[5];
    int exp_alt[7];
    int guard;
    logic [LED_NUM-1:0] frozen;

    exp_shl = '{1, 2, 4, 8, 1};
`ifdef LED_PATTERN_CTRL_BOUNCE_EN
    exp_alt = '{1, 2, 4, 8, 4, 2, 1};
`else
    exp_alt = '{15, 0, 15, 0, 15, 0, 15};
`endif
    model_reset();

    // Held in reset
    repeat (3) tick();
    check("reset_led", 32'(led_sig), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    tick();

    // SHIFT_L, period 0
    issue(1, 0);
    check("shl_seed", 32'(led_sig), 32'(exp_shl[0]));
    for (int i = 1; i < 5; i++) begin
      repeat (4) tick();
      check("shl_seq", 32'(led_sig), 32'(exp_shl[i]));
    end

    // Pause for 10 cycles mid-interval
    repeat (2) tick();
    frozen = led_sig;
    pause = 1'b1;
    repeat (10) tick();
    check("pause_frozen", 32'(led_sig), 32'(frozen));
    pause = 1'b0;
    repeat (12) tick();

    // SHIFT_R, period 2
    issue(2, 2);
    check("shr_seed", 32'(led_sig), 32'h8);
    repeat (12) tick();
    check("shr_step1", 32'(led_sig), 32'h4);
    repeat (12) tick();
    check("shr_step2", 32'(led_sig), 32'h2);

    // Collision: OFF command on the edge where a step would fire
    guard = 0;
    while (!(m_running && !m_paused && !m_pend && ((m_elapsed + 1) % interval() == 0))
           && guard < 100) begin
      tick();
      guard++;
    end
    check("collision_wait", 32'(guard < 100), 32'd1);
    issue(0, 0);
    check("collision_led", 32'(led_sig), 32'd0);
    check("collision_mode", 32'(mode_cur), 32'd0);

    // Mode 3, period 0
    issue(3, 0);
    check("alt_seed", 32'(led_sig), 32'(exp_alt[0]));
    for (int i = 1; i < 7; i++) begin
      repeat (4) tick();
      check("alt_seq", 32'(led_sig), 32'(exp_alt[i]));
    end

    // Random commands and pause
    repeat (800) begin
      cmd_valid = ($urandom_range(0, 15) == 0);
      cmd_mode = 2'($urandom_range(0, 3));
      cmd_period = 4'($urandom_range(0, 2));
      if ($urandom_range(0, 11) == 0) pause = ~pause;
      tick();
    end
    cmd_valid = 1'b0;
    pause = 1'b0;

    // Asynchronous reset mid-run
    issue(1, 0);
    repeat (6) tick();
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    check("async_rst_led", 32'(led_sig), 32'd0);
    check("async_rst_mode", 32'(mode_cur), 32'd0);
    check("async_rst_ready", 32'(cmd_ready), 32'd1);
    repeat (2) tick();
    @(negedge clk);
    rst = 1'b1;
    issue(2, 0);
    repeat (8) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/led_pattern_ctrl.md
# led_pattern_ctrl

Sequencer for the board LED bank: accepts mode commands over a valid/ready handshake from the key/UART front end and drives an `LED_NUM`-wide one-hot or blink pattern, stepping at a programmable rate. The block sits between the command source and the LED pins. It replaces free-running waterfall logic with a commandable, pausable pattern engine.

## Interface
- `CLK_DIV`, 2_499_999: prescaler terminal count; a base tick occurs every `CLK_DIV+1` clk cycles (0.1 s at 25 MHz).
- `CNT_W`, 24: prescaler width; must hold `CLK_DIV`.
- `LED_NUM`, 4: LED count; must be at least 2.
- `clk`  in  1  system clock.
- `rst`  in  1  reset, asynchronous, active-low.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  block can accept a command.
- `cmd_mode`  in  2  0 OFF, 1 SHIFT_L, 2 SHIFT_R, 3 ALT (BLINK or BOUNCE; see Configuration).
- `cmd_period`  in  4  steps occur every `cmd_period+1` base ticks.
- `pause`  in  1  level; freezes stepping while high.
- `led_sig`  out  `LED_NUM`  LED drive, registered.
- `mode_cur`  out  2  currently active mode, registered.

## Operation
- FSM states: S_OFF, S_LOAD, S_RUN, S_HOLD. Reset state is S_OFF.
- **Command acceptance:** a command is accepted on `cmd_valid && cmd_ready`. `cmd_ready` is 0 only in S_LOAD. Any state except S_LOAD transitions to S_LOAD on accept, latching the mode and period.
- **S_LOAD (1 cycle):**
  - Clears the prescaler and the step counter.
  - Loads the seed:
    - OFF: all 0.
    - SHIFT_L and BOUNCE: `...0001`, with direction set to left.
    - SHIFT_R: `1000...`.
    - BLINK: all 1.
  - Next state is S_OFF for mode 0, otherwise S_RUN.
- **S_RUN:**
  - The prescaler counts 0..`CLK_DIV`; at wrap, the step counter counts 0..period. A step fires when both wrap together.
  - Step actions:
    - SHIFT_L: `{led[N-2:0], led[N-1]}`.
    - SHIFT_R: `{led[0], led[N-1:1]}`.
    - BLINK: `~led`.
    - BOUNCE: shift in the current direction; direction reverses when the new value reaches the MSB or LSB end.
  - `pause` high moves to S_HOLD.
- **S_HOLD:** counters and `led_sig` are frozen. `pause` low returns to S_RUN, and counting resumes from the frozen values.
- `pause` is ignored in S_OFF and S_LOAD.
- **Simultaneous events:**
  - An accepted command beats a step in the same cycle; the step is discarded.
  - An accepted command beats `pause` in the same cycle.
- **Reset:** asserting reset at any time, including mid-S_LOAD, forces:
  - `led_sig` = 0
  - `mode_cur` = 0
  - `cmd_ready` = 1
  - state S_OFF, with counters and direction at 0.

## Timing
- Accept at edge k. Then at edge k+1:
  - `led_sig` holds the seed.
  - `mode_cur` holds the new mode.
  - `cmd_ready` returns to 1.
- First step lands `(CLK_DIV+1)*(cmd_period+1)` cycles after edge k+1; later steps follow at the same interval.
- Pause latency is 1 cycle: the edge on which `pause` is sampled high performs no count.
- Back-to-back commands are possible at most every 2 cycles.

## Configuration
- `LED_PATTERN_CTRL_BOUNCE_EN`
  - Defined: mode 3 is BOUNCE, and the direction register is present.
  - Undefined: mode 3 is BLINK, and no direction register exists.

## Structure
- Package `led_ctrl_pkg` holds:
  - mode encodings MODE_OFF/SHL/SHR/ALT;
  - FSM state encodings;
  - seed constants.
- Sub-module `led_tick_gen` holds the prescaler and step counter. It has inputs `clr`, `en`, `period` and outputs a 1-cycle `step` pulse.
- Top level holds the FSM, handshake, and pattern register.

## Test plan
All scenarios use `CLK_DIV`=3 and `LED_NUM`=4.
- **Reset:** assert `rst` low mid-run → `led_sig`=0000, `mode_cur`=0, `cmd_ready`=1 immediately.
- **SHIFT_L:** mode 1, period 0 → `led_sig` 0001 at k+1, then 0010, 0100, 1000, 0001 every 4 cycles; `cmd_ready` low exactly 1 cycle.
- **SHIFT_R:** mode 2, period 2 → 1000, then 0100 after 12 cycles, then 0010 after 12 more.
- **Pause:** in SHIFT_L, raise `pause` for 10 cycles → no change while high; next step arrives at the remaining count after release.
- **Collision:** command (mode 0) in the same cycle as a step fire → the step is suppressed and `led_sig`=0000 at k+1.
- **Mode 3 with the macro defined:** sequence 0001, 0010, 0100, 1000, 0100, 0010, 0001.
- **Mode 3 without the macro:** 1111, 0000, 1111.
